if_fetch_queue: RTL



---
 rtl/if_fetch_queue.sv | 123 ++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage with a small prefetch FIFO.
// Issues sequential fetches to memory port 1, pairs each returning word with its
// PC, and buffers the pairs so a stalled decode stage never loses an instruction.
// A redirect from execute restarts fetch at a new target and flushes everything
// buffered or in flight.
//
// DEPTH must be a power of two and at least 2: the pointers carry one extra wrap
// bit so that a full FIFO and an empty FIFO can be told apart.

module if_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] NOP_IR   = 32'h0000_0013
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    output logic [31:0]              IMEM_ADDR,
    output logic                     IMEM_RD,
    input  logic [31:0]              IMEM_DOUT,
    input  logic                     REDIRECT,
    input  logic [31:0]              REDIRECT_PC,
    input  logic                     DE_STALL,
    output logic                     IF_DE_VALID,
    output logic [31:0]              IF_DE_IR,
    output logic [31:0]              IF_DE_PC,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [31:0]   fetch_pc;
    logic          pending;
    logic [31:0]   pending_pc;
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [31:0]   fifo_ir [DEPTH];
    logic [31:0]   fifo_pc [DEPTH];

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [PW:0]   occupancy;
    logic          issue;
    logic          push;
    logic          pop;

    assign rd_idx      = rd_ptr[AW-1:0];
    assign wr_idx      = wr_ptr[AW-1:0];
    assign FIFO_COUNT  = wr_ptr - rd_ptr;
    assign IF_DE_VALID = (FIFO_COUNT != '0);

    // Issue/push/pop decisions; a redirect overrides throttling, drops the
    // returning response and suppresses any pop in the same cycle.
    always_comb begin
        occupancy = {1'b0, FIFO_COUNT} + {{PW{1'b0}}, pending};
        issue     = RST_N && (REDIRECT || (occupancy < (PW+1)'(DEPTH)));
        push      = pending && !REDIRECT;
        pop       = IF_DE_VALID && !DE_STALL && !REDIRECT;
        IMEM_RD   = issue;
        IMEM_ADDR = (RST_N && REDIRECT) ? REDIRECT_PC : fetch_pc;
    end

    // Head of the FIFO goes straight to decode; a NOP is shown when empty.
    always_comb begin
        IF_DE_IR = NOP_IR;
        IF_DE_PC = 32'h0000_0000;
        if (IF_DE_VALID) begin
            IF_DE_IR = fifo_ir[rd_idx];
            IF_DE_PC = fifo_pc[rd_idx];
        end
    end

    // Fetch PC and the single outstanding request it has in flight.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            fetch_pc   <= RESET_PC;
            pending    <= 1'b0;
            pending_pc <= 32'h0000_0000;
        end else if (REDIRECT) begin
            fetch_pc   <= REDIRECT_PC + 32'd4;
            pending    <= 1'b1;
            pending_pc <= REDIRECT_PC;
        end else if (issue) begin
            fetch_pc   <= fetch_pc + 32'd4;
            pending    <= 1'b1;
            pending_pc <= fetch_pc;
        end else begin
            pending    <= 1'b0;
        end
    end

    // FIFO pointers; a flush moves the read pointer onto the write pointer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (REDIRECT) begin
                rd_ptr <= wr_ptr;
            end else if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    // Storage for {IR, PC} pairs; contents need no reset since the pointers gate them.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_ir[wr_idx] <= IMEM_DOUT;
            fifo_pc[wr_idx] <= pending_pc;
        end
    end

`ifndef SYNTHESIS
    // The throttle on issue must never let a response arrive into a full FIFO.
    a_no_overflow : assert property (@(posedge CLK) disable iff (!RST_N)
        push |-> (FIFO_COUNT < PW'(DEPTH)));
`endif

endmodule
